pwm_duty_sequencer: RTL and testbench

//   Upstream duty-cycle source for the LED PWM stage. Produces a "breathing"

---
 rtl/pwm_duty_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer
// Breathing-ramp duty source for the LED PWM stage. Duty walks a triangle
// (UP, HOLD_HI, DOWN, HOLD_LO) between DUTY_MIN and DUTY_MAX. It only moves on
// frame_start, which the PWM stage raises at its counter wrap, so the
// comparator never sees a duty change partway through a PWM period.
module pwm_duty_sequencer #(
  parameter int DUTY_MIN        = 0,
  parameter int DUTY_MAX        = 100,
  parameter int STEP            = 1,
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_FRAMES     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_start,
  output logic [7:0] duty,
  output logic       duty_update,
  output logic       ramp_up
);

  // The frame counter must hold values up to max(FRAMES_PER_STEP, HOLD_FRAMES) - 1.
  localparam int CNT_MAX = (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [7:0]       DUTY_MIN_V = 8'(DUTY_MIN);
  localparam logic [7:0]       DUTY_MAX_V = 8'(DUTY_MAX);
  localparam logic [8:0]       STEP_V     = 9'(STEP);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam bit               NO_HOLD    = (HOLD_FRAMES == 0);

  // Reject illegal parameter sets during elaboration.
  if (!(DUTY_MIN >= 0 && DUTY_MIN < DUTY_MAX && DUTY_MAX <= 255)) begin : g_bad_range
    $error("pwm_duty_sequencer: need 0 <= DUTY_MIN < DUTY_MAX <= 255");
  end
  if (STEP < 1 || STEP > 255) begin : g_bad_step
    $error("pwm_duty_sequencer: STEP must be in 1..255");
  end
  if (FRAMES_PER_STEP < 1) begin : g_bad_fps
    $error("pwm_duty_sequencer: FRAMES_PER_STEP must be >= 1");
  end
  if (HOLD_FRAMES < 0) begin : g_bad_hold
    $error("pwm_duty_sequencer: HOLD_FRAMES must be >= 0");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             duty_update_q, duty_update_d;
  logic             ramp_up_q, ramp_up_d;

  // Candidate duty values one step up and one step down, computed at 9 bits
  // and clamped so that no legal STEP/DUTY_MAX combination can wrap.
  logic [8:0] sum_up;
  logic [8:0] floor_plus_step;
  logic [7:0] duty_stepped_up;
  logic [7:0] duty_stepped_dn;

  // Clamped step arithmetic shared by the UP and DOWN states.
  always_comb begin
    sum_up          = {1'b0, duty_q} + STEP_V;
    floor_plus_step = {1'b0, DUTY_MIN_V} + STEP_V;
    duty_stepped_up = (sum_up >= {1'b0, DUTY_MAX_V}) ? DUTY_MAX_V : sum_up[7:0];
    duty_stepped_dn = ({1'b0, duty_q} < floor_plus_step) ? DUTY_MIN_V
                                                         : (duty_q - STEP_V[7:0]);
  end

  // State register plus the registered duty, ramp_up and update pulse.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling the pre-edge
    // values, so the order of these statements does not matter.
    if (rst) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      duty_q        <= DUTY_MIN_V;
      duty_update_q <= 1'b0;
      ramp_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      duty_q        <= duty_d;
      duty_update_q <= duty_update_d;
      ramp_up_q     <= ramp_up_d;
    end
  end

  // Next-state logic: everything advances only on a frame_start cycle.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    duty_d      = duty_q;

    if (frame_start) begin
      if (state_q == IDLE) begin
        if (enable) begin
          state_d     = UP;
          frame_cnt_d = '0;
        end
      end else if (!enable) begin
        state_d     = IDLE;
        frame_cnt_d = '0;
        duty_d      = DUTY_MIN_V;
      end else begin
        unique case (state_q)
          UP: begin
            if (frame_cnt_q == STEP_LAST) begin
              frame_cnt_d = '0;
              duty_d      = duty_stepped_up;
              if (duty_stepped_up == DUTY_MAX_V) begin
                state_d = NO_HOLD ? DOWN : HOLD_HI;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
          HOLD_HI: begin
            if (frame_cnt_q == HOLD_LAST) begin
              state_d     = DOWN;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
          DOWN: begin
            if (frame_cnt_q == STEP_LAST) begin
              frame_cnt_d = '0;
              duty_d      = duty_stepped_dn;
              if (duty_stepped_dn == DUTY_MIN_V) begin
                state_d = NO_HOLD ? UP : HOLD_LO;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
          HOLD_LO: begin
            if (frame_cnt_q == HOLD_LAST) begin
              state_d     = UP;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d     = IDLE;
            frame_cnt_d = '0;
            duty_d      = DUTY_MIN_V;
          end
        endcase
      end
    end
  end

  // Output logic: registered versions follow the next state and duty.
  always_comb begin
    ramp_up_d     = (state_d == UP) || (state_d == HOLD_HI);
    duty_update_d = (duty_d != duty_q);
  end

  assign duty        = duty_q;
  assign duty_update = duty_update_q;
  assign ramp_up     = ramp_up_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer
// Directed bench: dut_a uses the small ramp (max 10, step 3, 2 frames/step,
// 3 hold frames); dut_b uses max 255, step 200, no hold to exercise clamping.
module tb_pwm_duty_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fs_a, fs_b;
  logic [7:0] duty_a, duty_b;
  logic       upd_a, upd_b;
  logic       ru_a, ru_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_duty_sequencer #(
    .DUTY_MIN(0), .DUTY_MAX(10), .STEP(3), .FRAMES_PER_STEP(2), .HOLD_FRAMES(3)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(fs_a),
    .duty(duty_a), .duty_update(upd_a), .ramp_up(ru_a)
  );

  pwm_duty_sequencer #(
    .DUTY_MIN(0), .DUTY_MAX(255), .STEP(200), .FRAMES_PER_STEP(2), .HOLD_FRAMES(0)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(fs_b),
    .duty(duty_b), .duty_update(upd_b), .ramp_up(ru_b)
  );

  // Expected values right after each frame_start of a ramp begun from IDLE.
  int exp_duty_a[25] = '{0,0,3,3,6,6,9,9,10,10,10,10,10,7,7,4,4,1,1,0,0,0,0,0,3};
  int exp_upd_a [25] = '{0,0,1,0,1,0,1,0,1, 0, 0, 0, 0,1,0,1,0,1,0,1,0,0,0,0,1};
  int exp_ru_a  [25] = '{1,1,1,1,1,1,1,1,1, 1, 1, 0, 0,0,0,0,0,0,0,0,0,0,1,1,1};

  int exp_duty_b[11] = '{0,0,200,200,255,255,55,55,0,0,200};
  int exp_upd_b [11] = '{0,0,1,0,1,0,1,0,1,0,1};
  int exp_ru_b  [11] = '{1,1,1,1,0,0,0,0,1,1,1};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame, 8 clk long: pulse frame_start, check outputs one cycle later,
  // then check the update pulse has dropped and duty holds.
  task automatic frame(input bit sel, input int ed, input int eu, input int er,
                       input string tag);
    @(negedge clk);
    if (sel) fs_b = 1'b1; else fs_a = 1'b1;
    @(negedge clk);
    fs_a = 1'b0;
    fs_b = 1'b0;
    check({tag, " duty"},    int'(sel ? duty_b : duty_a), ed);
    check({tag, " update"},  int'(sel ? upd_b  : upd_a),  eu);
    check({tag, " ramp_up"}, int'(sel ? ru_b   : ru_a),   er);
    @(negedge clk);
    check({tag, " update_drop"}, int'(sel ? upd_b : upd_a), 0);
    check({tag, " duty_hold"},   int'(sel ? duty_b : duty_a), ed);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_a(input int n, input string pfx);
    for (int i = 0; i < n; i++)
      frame(1'b0, exp_duty_a[i], exp_upd_a[i], exp_ru_a[i], $sformatf("%s f%0d", pfx, i + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with frame_start and enable asserted: reset must win.
    rst    = 1'b1;
    enable = 1'b1;
    fs_a   = 1'b1;
    fs_b   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d duty", i),    int'(duty_a), 0);
      check($sformatf("rst%0d update", i),  int'(upd_a),  0);
      check($sformatf("rst%0d ramp_up", i), int'(ru_a),   0);
      check($sformatf("rst%0d duty_b", i),  int'(duty_b), 0);
    end
    rst  = 1'b0;
    fs_a = 1'b0;
    fs_b = 1'b0;

    // Full breathing cycle and back into UP.
    run_a(25, "ramp");

    // Long gap without frame_start mid-UP: nothing may move.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("gap duty",    int'(duty_a), 3);
      check("gap ramp_up", int'(ru_a),   1);
      check("gap update",  int'(upd_a),  0);
    end

    // Step to 6, drop enable between frames (no effect until frame_start).
    frame(1'b0, 3, 0, 1, "pre f26");
    frame(1'b0, 6, 1, 1, "pre f27");
    @(negedge clk);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("dis_wait duty",    int'(duty_a), 6);
      check("dis_wait ramp_up", int'(ru_a),   1);
    end
    frame(1'b0, 0, 1, 0, "disable");
    frame(1'b0, 0, 0, 0, "idle_off");

    // Re-enable restarts from 0; run into DOWN at duty 7, then reset.
    enable = 1'b1;
    run_a(15, "restart");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset duty",    int'(duty_a), 0);
    check("midreset ramp_up", int'(ru_a),   0);
    check("midreset update",  int'(upd_a),  0);
    run_a(25, "resume");

    // Wide step with saturation at both ends, no hold frames.
    for (int i = 0; i < 11; i++)
      frame(1'b1, exp_duty_b[i], exp_upd_b[i], exp_ru_b[i], $sformatf("wide f%0d", i + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
